regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Shares the register file's single write port (write_register / write_data / reg_write)
//  among NUM_REQ writeback sources, e.g. ALU, load unit and CSR.
//  - Round-robin grant of one request per cycle; valid/ready handshake per requester.
//  - Granted write is registered and presented to the register file one cycle later.
//  - Sits between the execute/memory writeback sources and the registers block.
// PARAMETERS
//  NUM_REQ   2   number of writeback requesters (legal 1..8)
//  XLEN      32  data width of write_data
//  ADDR_W    5   register address width (32 architectural registers)
// PORTS
//  clk             in   1               rising-edge clock
//  reset           in   1               asynchronous, active-high reset
//  req_valid       in   NUM_REQ         requester i holds a write request
//  req_rd          in   NUM_REQ*ADDR_W  destination register, requester i in bits [i*ADDR_W +: ADDR_W]
//  req_data        in   NUM_REQ*XLEN    write data, requester i in bits [i*XLEN +: XLEN]
//  req_ready       out  NUM_REQ         one-hot grant; the request is accepted when valid & ready
//  write_register  out  ADDR_W          register file write address (registered)
//  write_data      out  XLEN            register file write data (registered)
//  reg_write       out  1               register file write enable (registered, one-cycle pulse)
//  busy_mask       out  32              bit r is set while a write to register r is in the output stage
// BEHAVIOUR
//  - Reset (async, while high): write_register=0, write_data=0, reg_write=0, busy_mask=0,
//    round-robin pointer=0. req_ready is combinational and therefore 0 while no request is valid.
//  - Grant is combinational:
//    - Search starts at pointer ptr and wraps modulo NUM_REQ.
//    - The first i with req_valid[i]=1 gets req_ready[i]=1. All other ready bits are 0.
//    - No valid requests: req_ready is all 0.
//  - Pointer update: on each cycle with a grant to i, ptr <= (i+1) mod NUM_REQ. The pointer is unchanged when nothing is granted.
//  - Latency: a request accepted in cycle N drives reg_write=1, write_register=rd and
//    write_data=data in cycle N+1. With no acceptance in N, reg_write=0 in cycle N+1.
//  - While reg_write=0, write_register and write_data hold their last values.
//  - x0 filtering:
//    - A request with rd=0 is accepted normally and consumes its grant slot.
//    - It produces reg_write=0 in cycle N+1.
//    - The busy_mask bit is not set.
//  - busy_mask: exactly one bit (write_register) is set in cycles where reg_write=1. Otherwise it is all 0.
//  - Throughput: one write per cycle in total. There is no downstream backpressure, because the register file always accepts.
//  - Requester rules:
//    - A requester that is not granted keeps req_valid, req_rd and req_data stable until it is granted.
//    - The arbiter never drops an accepted request.
//  - Simultaneous requests: the same rd from two requesters in one cycle is allowed.
//    - The writes are serialized in grant order, so the last write granted wins.
//  - Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
//  - Reset mid-operation: the pending output-stage write is discarded (reg_write forced 0).
//    No request accepted in the cycle of reset deassertion is lost, because ready is computed from the reset pointer.
//  - NUM_REQ=1: req_ready[0]=req_valid[0]. The pointer stays 0.
// STRUCTURE
//  - Shared package/header (rv_defs): XLEN, REG_ADDR_W and NUM_ARCH_REGS=32 constants.
//    The X0 address constant 5'd0 also lives there.
//  - Sub-module rr_arbiter (params N): inputs req[N] and ptr, outputs grant[N] (one-hot) and grant_idx.
//    It is purely combinational; the pointer register lives in this block.
//  - This block contains: pointer register, request mux selected by grant_idx, output stage registers, busy_mask decode.
// TESTING
//  - Reset: assert reset mid-run with reg_write=1 -> all outputs read 0 in the same cycle, ptr=0 after release.
//  - Single requester: req_valid[0]=1, rd=2, data=24 in cycle N ->
//    req_ready[0]=1 in cycle N; in cycle N+1 reg_write=1, write_register=2, write_data=24, busy_mask=32'h4.
//  - Contention: both requesters valid with rd=3/d=7 and rd=4/d=9 and ptr=0 ->
//    grant order 0 then 1; writes 3<=7 then 4<=9 on consecutive cycles; requester 1 held stable until granted.
//  - Fairness: both requesters valid for 8 cycles -> grants alternate 0,1,0,1,...; 4 grants each.
//  - x0: req_valid[1]=1, rd=0, data=32'hFFFF_FFFF -> req_ready[1]=1; next cycle reg_write=0, busy_mask=0.
//  - Same-rd race: both requesters target rd=5 with data 1 and 2 -> two writes; final write to x5 is from the later grant.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants for the register-file write path: data width, register
// address width, architectural register count and the hard-wired zero register.
package regfile_write_arbiter_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 32;

  // x0 always reads zero, so writes addressed to it are swallowed.
  localparam logic [REG_ADDR_W-1:0] X0_ADDR = 5'd0;

  // Index width for a requester count; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin grant selection. Purely combinational: the requester closest to
// ptr (counting upward and wrapping modulo N) wins. The pointer register itself
// lives in the parent block.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic any_req;
  int   best_rank;
  int   rank;

  assign any_req = |req;

  // Pick the valid requester with the smallest wrapped distance from ptr.
  // NOTE: every variable written here gets a value before any conditional
  // logic, so no path leaves a stale value behind and no latch is inferred.
  always_comb begin
    best_rank = N;
    rank      = 0;
    grant_idx = '0;
    grant     = '0;
    for (int i = 0; i < N; i++) begin
      rank = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
      if (req[i] && (rank < best_rank)) begin
        best_rank = rank;
        grant_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = any_req && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback
// sources. One request is granted per cycle in round-robin order; the granted
// write is registered and presented to the register file on the next cycle.
// Writes addressed to x0 are accepted but never reach the register file.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = regfile_write_arbiter_pkg::XLEN,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         write_register,
  output logic [XLEN-1:0]           write_data,
  output logic                      reg_write,
  output logic [NUM_ARCH_REGS-1:0]  busy_mask
);

  localparam int IDX_W = idx_width(NUM_REQ);

  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               accept;
  logic [ADDR_W-1:0]  sel_rd;
  logic [XLEN-1:0]    sel_data;
  logic               sel_is_x0;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready is withheld while reset is high: the output stage is being
  // cleared then, so a handshake completed during reset would be lost.
  assign req_ready = reset ? '0 : grant;
  assign accept    = |req_ready;

  // Route the granted requester's destination and data to the output stage.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_is_x0 = (sel_rd == ADDR_W'(X0_ADDR));

  // Advance the pointer to the slot just after the winner, wrapping at NUM_REQ.
  always_comb begin
    ptr_next = ptr;
    if (accept) begin
      ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  // Round-robin pointer register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

  // Output stage: one write-enable pulse per accepted non-x0 request; the
  // address and data hold their last values whenever no write is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      reg_write <= accept && !sel_is_x0;
      if (accept && !sel_is_x0) begin
        write_register <= sel_rd;
        write_data     <= sel_data;
      end
    end
  end

  // Flag the register currently being written so hazard logic can see it.
  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      busy_mask[r] = reg_write && (write_register == ADDR_W'(r));
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: the stimulus side predicts grants
// with a simple round-robin model and queues expected writes; a monitor pops
// and compares whenever the register-file port shows activity.
module tb_regfile_write_arbiter;

  localparam int NUM_REQ = 2;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 5;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] rd;
    logic [XLEN-1:0]   data;
  } wr_t;

  logic                      clk;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_rd;
  logic [NUM_REQ*XLEN-1:0]   req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [ADDR_W-1:0]         write_register;
  logic [XLEN-1:0]           write_data;
  logic                      reg_write;
  logic [31:0]               busy_mask;

  int              passed = 0;
  int              total  = 0;
  int              cyc    = 0;
  int              ref_ptr = 0;
  int              grants [NUM_REQ];
  wr_t             exp_q [$];
  logic [XLEN-1:0] exp_rf [32];
  logic [XLEN-1:0] dut_rf [32];

  regfile_write_arbiter #(
    .NUM_REQ (NUM_REQ),
    .XLEN    (XLEN),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_rd         (req_rd),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .write_register (write_register),
    .write_data     (write_data),
    .reg_write      (reg_write),
    .busy_mask      (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] rd,
                         input logic [XLEN-1:0] data);
    req_valid[i]              = v;
    req_rd[i*ADDR_W +: ADDR_W] = rd;
    req_data[i*XLEN +: XLEN]  = data;
  endtask

  // One clock cycle: predict and check the grant at the falling edge, queue
  // the write it should cause, then return just after the next rising edge.
  task automatic step(output int g);
    logic [NUM_REQ-1:0] exp_ready;
    logic [ADDR_W-1:0]  rd;
    @(negedge clk);
    g = -1;
    for (int off = 0; off < NUM_REQ; off++) begin
      int i;
      i = (ref_ptr + off) % NUM_REQ;
      if (g < 0 && req_valid[i]) g = i;
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    if (g >= 0) begin
      ref_ptr = (g + 1) % NUM_REQ;
      grants[g]++;
      rd = req_rd[g*ADDR_W +: ADDR_W];
      if (rd != '0) begin
        exp_q.push_back('{cyc: cyc + 1, rd: rd, data: req_data[g*XLEN +: XLEN]});
        exp_rf[rd] = req_data[g*XLEN +: XLEN];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    ref_ptr = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: every visible write must match the oldest queued expectation in
  // both content and cycle; idle cycles must show an empty busy mask.
  always @(negedge clk) begin
    if (!reset) begin
      if (reg_write) begin
        if (exp_q.size() == 0) begin
          check("unexpected write", 64'(write_register), 64'hFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("write cycle", 64'(cyc), 64'(e.cyc));
          check("write_register", 64'(write_register), 64'(e.rd));
          check("write_data", 64'(write_data), 64'(e.data));
          check("busy_mask", 64'(busy_mask), 64'(32'h1 << e.rd));
          dut_rf[write_register] = write_data;
        end
      end else begin
        check("idle busy_mask", 64'(busy_mask), 64'h0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          wr_t e;
          e = exp_q.pop_front();
          check("missing write", 64'(reg_write), 64'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int g;
    reset     = 1'b1;
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    for (int r = 0; r < 32; r++) begin
      exp_rf[r] = '0;
      dut_rf[r] = '0;
    end
    for (int i = 0; i < NUM_REQ; i++) grants[i] = 0;

    // Reset values.
    #12;
    check("rst reg_write", 64'(reg_write), 64'h0);
    check("rst write_register", 64'(write_register), 64'h0);
    check("rst write_data", 64'(write_data), 64'h0);
    check("rst busy_mask", 64'(busy_mask), 64'h0);
    check("rst req_ready", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single requester: x2 <= 24.
    set_req(0, 1'b1, 5'd2, 32'd24);
    step(g);
    set_req(0, 1'b0, '0, '0);
    step(g);
    step(g);

    // Contention from pointer 0: x3 <= 7 then x4 <= 9, requester 1 held.
    apply_reset();
    set_req(0, 1'b1, 5'd3, 32'd7);
    set_req(1, 1'b1, 5'd4, 32'd9);
    step(g);
    check("contention first", 64'(g), 64'd0);
    set_req(0, 1'b0, '0, '0);
    step(g);
    check("contention second", 64'(g), 64'd1);
    set_req(1, 1'b0, '0, '0);
    step(g);
    step(g);

    // Fairness: both always valid for 8 cycles.
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) grants[i] = 0;
    set_req(0, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    set_req(1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    for (int k = 0; k < 8; k++) begin
      step(g);
      if (g >= 0) set_req(g, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    end
    check("fair grants req0", 64'(grants[0]), 64'd4);
    check("fair grants req1", 64'(grants[1]), 64'd4);
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    step(g);
    step(g);

    // x0 write is accepted but filtered.
    set_req(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(g);
    check("x0 granted", 64'(g), 64'd1);
    check("x0 reg_write", 64'(reg_write), 64'h0);
    check("x0 busy_mask", 64'(busy_mask), 64'h0);
    set_req(1, 1'b0, '0, '0);
    step(g);

    // Same-rd race: the later grant owns x5.
    apply_reset();
    set_req(0, 1'b1, 5'd5, 32'd1);
    set_req(1, 1'b1, 5'd5, 32'd2);
    step(g);
    set_req(0, 1'b0, '0, '0);
    step(g);
    set_req(1, 1'b0, '0, '0);
    step(g);
    step(g);
    check("race x5 model", 64'(dut_rf[5]), 64'(exp_rf[5]));
    check("race x5 value", 64'(dut_rf[5]), 64'd2);

    // Reset while a write is in the output stage; pointer must restart at 0.
    apply_reset();
    set_req(0, 1'b1, 5'd7, 32'd3);
    step(g);
    set_req(0, 1'b0, '0, '0);
    check("pre-reset reg_write", 64'(reg_write), 64'h1);
    reset = 1'b1;
    #1;
    check("mid rst reg_write", 64'(reg_write), 64'h0);
    check("mid rst write_register", 64'(write_register), 64'h0);
    check("mid rst write_data", 64'(write_data), 64'h0);
    check("mid rst busy_mask", 64'(busy_mask), 64'h0);
    exp_q.delete();
    ref_ptr = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_req(0, 1'b1, 5'd8, 32'd80);
    set_req(1, 1'b1, 5'd9, 32'd90);
    step(g);
    check("post-reset ptr grant", 64'(g), 64'd0);
    set_req(0, 1'b0, '0, '0);
    step(g);
    set_req(1, 1'b0, '0, '0);
    step(g);

    // Randomized traffic; a pending request is held stable until granted.
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 9) < 6)
          set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
      end
      step(g);
      if (g >= 0) set_req(g, 1'b0, '0, '0);
    end
    req_valid = '0;
    step(g);
    step(g);
    step(g);
    check("queue drained", 64'(exp_q.size()), 64'd0);
    for (int r = 1; r < 32; r++) check("final regfile", 64'(dut_rf[r]), 64'(exp_rf[r]));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
